helix4_action_arbiter: RTL and testbench

- Merges the four per-die action streams of the quad cluster into one shared action port toward the world interface.
- Dies map to roles LookIn=0, SpiralUp=1, FlowOut=2, Return=3.
- Round-robin grant with a single registered output stage, so throughput is one beat per cycle under backpressure-free conditions.
- Tags every output beat with its source die ID so downstream logic can route completions back.

---
 rtl/helix_pkg.sv | 22 ++
 rtl/helix4_action_arbiter_if.sv | 26 ++
 rtl/helix_rr_pick.sv | 25 ++
 rtl/helix4_action_arbiter.sv | 88 ++++++++
 tb/tb_helix4_action_arbiter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/helix_pkg.sv
// Shared quad-cluster types: die IDs, die roles and the default action beat width.
package helix_pkg;

  localparam int unsigned HELIX_ACTION_W = 32;

  localparam int unsigned HELIX_NUM_DIES = 4;

  typedef logic [1:0] die_id_t;

  typedef enum logic [1:0] {
    LOOK_IN   = 2'd0,
    SPIRAL_UP = 2'd1,
    FLOW_OUT  = 2'd2,
    RETURN    = 2'd3
  } die_role_e;

  // Successor in the ring; the 2-bit ID wraps 3 -> 0 on its own.
  function automatic die_id_t next_die(input die_id_t id);
    return id + 2'd1;
  endfunction

endpackage

// File: rtl/helix4_action_arbiter_if.sv
// Per-die action inputs plus merged action output of the quad-cluster arbiter.
// master drives requests and out_ready; slave is the arbiter.
interface helix4_action_arbiter_if #(
  parameter int unsigned ACTION_W = helix_pkg::HELIX_ACTION_W
);
  import helix_pkg::*;

  logic [3:0]               in_valid;
  logic [3:0]               in_ready;
  logic [3:0][ACTION_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACTION_W-1:0]      out_data;
  die_id_t                  out_src;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/helix_rr_pick.sv
// Combinational rotating-priority encoder: first set req bit at or after ptr, wrapping.
// Shared with the ingress distributor.
module helix_rr_pick
  import helix_pkg::*;
(
  input  logic [3:0] req,
  input  die_id_t    ptr,
  output logic       gnt_valid,
  output die_id_t    gnt_idx
);

  always_comb begin
    die_id_t cand;
    gnt_valid = 1'b0;
    gnt_idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + die_id_t'(i);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/helix4_action_arbiter.sv
// Round-robin merge of four per-die action streams into one registered, source-tagged port.
// HELIX_ARB_STATS_EN adds saturating per-die accepted-beat counters on grant_count.
module helix4_action_arbiter
  import helix_pkg::*;
#(
  parameter int unsigned ACTION_W = HELIX_ACTION_W,
  parameter int unsigned NUM_DIES = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef HELIX_ARB_STATS_EN
  output logic [3:0][CNT_W-1:0]       grant_count,
`endif
  helix4_action_arbiter_if.slave      bus
);

  if (NUM_DIES != HELIX_NUM_DIES) begin : g_num_dies_chk
    $error("helix4_action_arbiter supports exactly 4 dies");
  end

  logic                out_valid_q;
  logic [ACTION_W-1:0] out_data_q;
  die_id_t             out_src_q;
  die_id_t             rr_ptr_q;

  logic    load;
  logic    gnt_valid;
  die_id_t gnt_idx;
  logic    take;

  helix_rr_pick u_rr_pick (
    .req       (bus.in_valid),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign load = !out_valid_q || bus.out_ready;
  // Gated by rst_n so no die sees a handshake while reset is asserted.
  assign take = load && gnt_valid && rst_n;

  always_comb begin
    bus.in_ready = 4'b0000;
    if (take) bus.in_ready = 4'b0001 << gnt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= LOOK_IN;
      rr_ptr_q    <= LOOK_IN;
    end else if (load) begin
      if (gnt_valid) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.in_data[gnt_idx];
        out_src_q   <= gnt_idx;
        rr_ptr_q    <= next_die(gnt_idx);
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

`ifdef HELIX_ARB_STATS_EN
  logic [3:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int g = 0; g < 4; g++) begin
        if (bus.in_valid[g] && bus.in_ready[g] && (cnt_q[g] != {CNT_W{1'b1}})) begin
          cnt_q[g] <= cnt_q[g] + 1'b1;
        end
      end
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_helix4_action_arbiter.sv
// Directed bench for helix4_action_arbiter: reset, round-robin order, single requester,
// backpressure, mid-transfer reset and (with HELIX_ARB_STATS_EN) counter saturation.
module tb_helix4_action_arbiter;
  import helix_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned CW = 4;

  logic clk;
  logic rst_n;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  logic hold_chk = 1'b0;
  logic [3:0] pending_q = 4'b0000;

  helix4_action_arbiter_if #(.ACTION_W(AW)) bus ();

`ifdef HELIX_ARB_STATS_EN
  logic [3:0][CW-1:0] grant_count;
`endif

  helix4_action_arbiter #(
    .ACTION_W (AW),
    .NUM_DIES (4),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef HELIX_ARB_STATS_EN
    .grant_count (grant_count),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A die left waiting must keep valid up; hold_chk is cleared where stimulus is switched.
  always @(posedge clk) begin
    if (rst_n && hold_chk && ((pending_q & ~bus.in_valid) != 4'b0000)) begin
      $error("input protocol: valid dropped before ready, pending=%b valid=%b",
             pending_q, bus.in_valid);
    end
    pending_q <= rst_n ? (bus.in_valid & ~bus.in_ready) : 4'b0000;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    hold_chk = 1'b1;
  endtask

  task automatic set_all_valid();
    hold_chk = 1'b0;
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) bus.in_data[i] = 8'hA0 + 8'(i);
  endtask

  initial begin
    logic [1:0] exp_src;

    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    set_all_valid();
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'b0000);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_src", 64'(bus.out_src), 64'd0);

    // Release between edges; die 0 has first priority.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 64'(bus.in_ready), 64'b0001);

    // Round-robin over all four dies, back to back.
    exp_src = LOOK_IN;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("rr_src_%0d", i), 64'(bus.out_src), 64'(exp_src));
      check($sformatf("rr_data_%0d", i), 64'(bus.out_data), 64'(8'hA0 + 8'(exp_src)));
      check($sformatf("rr_valid_%0d", i), 64'(bus.out_valid), 64'd1);
      exp_src = exp_src + 2'd1;
    end

    // Only die 2 requesting: granted every cycle regardless of rr_ptr.
    hold_chk = 1'b0;
    bus.in_valid = 4'b0100;
    bus.in_data[2] = 8'h55;
    #1;
    check("solo_in_ready", 64'(bus.in_ready), 64'b0100);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("solo_src_%0d", i), 64'(bus.out_src), 64'd2);
      check($sformatf("solo_data_%0d", i), 64'(bus.out_data), 64'h55);
      check($sformatf("solo_ready_%0d", i), 64'(bus.in_ready), 64'b0100);
    end

    // Backpressure: beat from die 2 held while all dies request.
    bus.out_ready = 1'b0;
    set_all_valid();
    #1;
    check("bp_in_ready", 64'(bus.in_ready), 64'b0000);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp_data_%0d", i), 64'(bus.out_data), 64'h55);
      check($sformatf("bp_src_%0d", i), 64'(bus.out_src), 64'd2);
      check($sformatf("bp_valid_%0d", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp_ready_%0d", i), 64'(bus.in_ready), 64'b0000);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.in_ready), 64'b1000);
    step();
    check("bp_reload_src", 64'(bus.out_src), 64'd3);
    check("bp_reload_data", 64'(bus.out_data), 64'hA3);
    check("bp_reload_valid", 64'(bus.out_valid), 64'd1);

    // Reset pulse with a stalled beat: out_valid drops without a clock edge.
    bus.out_ready = 1'b0;
    step();
    check("rp_pre_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rp_async_valid", 64'(bus.out_valid), 64'd0);
    check("rp_async_ready", 64'(bus.in_ready), 64'b0000);
    @(negedge clk);
    hold_chk = 1'b0;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("rp_rel_ready", 64'(bus.in_ready), 64'b0001);
    step();
    check("rp_first_src", 64'(bus.out_src), 64'd0);
    check("rp_first_data", 64'(bus.out_data), 64'hA0);

    // Idle inputs: register drains to empty.
    hold_chk = 1'b0;
    bus.in_valid = 4'b0000;
    step();
    check("idle_valid", 64'(bus.out_valid), 64'd0);
    check("idle_ready", 64'(bus.in_ready), 64'b0000);

`ifdef HELIX_ARB_STATS_EN
    rst_n = 1'b0;
    #1;
    check("st_rst_cnt", 64'(grant_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_chk = 1'b0;
    bus.in_valid = 4'b0010;
    bus.in_data[1] = 8'h11;
    for (int i = 0; i < 20; i++) step();
    hold_chk = 1'b0;
    bus.in_valid = 4'b0000;
    step();
    check("st_cnt1_sat", 64'(grant_count[1]), 64'd15);
    check("st_cnt0", 64'(grant_count[0]), 64'd0);
    check("st_cnt2", 64'(grant_count[2]), 64'd0);
    check("st_cnt3", 64'(grant_count[3]), 64'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
